oled_refresh: RTL and testbench

OLED_REFRESH -- requirements
Module: oled_refresh

---
 rtl/oled_refresh.sv | 182 ++++++++++++++++++
 tb/tb_oled_refresh.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_refresh.sv
// Purpose: OLED panel refresh sequencer (HW reset, init, then page/column streaming of framebuffer bytes).
// Latency: commands are driven in the same cycle dspi_ready is seen, and the cycle after each one is always a NOP.
// Backpressure: dspi_ready=0 stalls the issuing state. WAIT_DATA waits on d_data_ready with no timeout.
module oled_refresh #(
    parameter int COLUMNS   = 128,
    parameter int PAGES     = 8,
    parameter int FRAME_GAP = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dspi_ready,
    output logic [2:0] dspi_cmd,
    output logic [7:0] dspi_byte,
    output logic       d_read,
    input  logic [7:0] d_data,
    input  logic       d_data_ready,
    output logic       frame_done
);

    localparam int CW       = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int PW       = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam int GAP_LAST = (FRAME_GAP > 0) ? FRAME_GAP - 1 : 0;

    localparam logic [CW-1:0] COL_LAST  = CW'(COLUMNS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [GW-1:0] GAP_END   = GW'(GAP_LAST);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_HWRST = 3'd1;
    localparam logic [2:0] CMD_BYTE  = 3'd2;
    localparam logic [2:0] CMD_DATA  = 3'd3;

    typedef enum logic [2:0] {
        RST_DISP,
        INIT,
        PAGE_SET,
        FETCH,
        WAIT_DATA,
        SEND,
        GAP
    } state_t;

    state_t          r_state, w_state;
    logic [1:0]      r_idx, w_idx;
    logic [CW-1:0]   r_col, w_col;
    logic [PW-1:0]   r_page, w_page;
    logic [GW-1:0]   r_gap, w_gap;
    logic [7:0]      r_data, w_data;
    logic            r_cool;

    logic            w_can;
    logic [2:0]      w_cmd;
    logic [7:0]      w_byte;
    logic            w_read;
    logic            w_done;

    // Hold off for one cycle after any issue, because the engine only drops ready a cycle after it accepts.
    assign w_can = dspi_ready & ~r_cool & ~rst;

    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_col   = r_col;
        w_page  = r_page;
        w_gap   = r_gap;
        w_data  = r_data;
        w_cmd   = CMD_NOP;
        w_byte  = 8'h00;
        w_read  = 1'b0;
        w_done  = 1'b0;

        case (r_state)
            RST_DISP: begin
                if (w_can) begin
                    w_cmd   = CMD_HWRST;
                    w_idx   = 2'd0;
                    w_state = INIT;
                end
            end
            INIT: begin
                if (w_can) begin
                    w_cmd = CMD_BYTE;
                    case (r_idx)
                        2'd0:    w_byte = 8'hAE;
                        2'd1:    w_byte = 8'h8D;
                        2'd2:    w_byte = 8'h14;
                        default: w_byte = 8'hAF;
                    endcase
                    if (r_idx == 2'd3) begin
                        w_idx   = 2'd0;
                        w_page  = '0;
                        w_state = PAGE_SET;
                    end else begin
                        w_idx = r_idx + 2'd1;
                    end
                end
            end
            PAGE_SET: begin
                if (w_can) begin
                    w_cmd = CMD_BYTE;
                    case (r_idx)
                        2'd0:    w_byte = {5'b10110, 3'(r_page)};
                        2'd1:    w_byte = 8'h00;
                        default: w_byte = 8'h10;
                    endcase
                    if (r_idx == 2'd2) begin
                        w_idx   = 2'd0;
                        w_col   = '0;
                        w_state = FETCH;
                    end else begin
                        w_idx = r_idx + 2'd1;
                    end
                end
            end
            FETCH: begin
                w_read  = ~rst;
                w_state = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (d_data_ready) begin
                    w_data  = d_data;
                    w_state = SEND;
                end
            end
            SEND: begin
                if (w_can) begin
                    w_cmd  = CMD_DATA;
                    w_byte = r_data;
                    if (r_col != COL_LAST) begin
                        w_col   = r_col + CW'(1);
                        w_state = FETCH;
                    end else if (r_page != PAGE_LAST) begin
                        w_page  = r_page + PW'(1);
                        w_state = PAGE_SET;
                    end else begin
                        w_done  = 1'b1;
                        w_page  = '0;
                        w_col   = '0;
                        w_gap   = '0;
                        w_state = (FRAME_GAP == 0) ? PAGE_SET : GAP;
                    end
                end
            end
            GAP: begin
                if (r_gap == GAP_END) begin
                    w_gap   = '0;
                    w_state = PAGE_SET;
                end else begin
                    w_gap = r_gap + GW'(1);
                end
            end
            default: w_state = RST_DISP;
        endcase
    end

    assign dspi_cmd   = w_cmd;
    assign dspi_byte  = w_byte;
    assign d_read     = w_read;
    assign frame_done = w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_DISP;
            r_idx   <= '0;
            r_col   <= '0;
            r_page  <= '0;
            r_gap   <= '0;
            r_data  <= '0;
            r_cool  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_idx   <= w_idx;
            r_col   <= w_col;
            r_page  <= w_page;
            r_gap   <= w_gap;
            r_data  <= w_data;
            r_cool  <= (w_cmd != CMD_NOP);
        end
    end

endmodule

// File: tb/tb_oled_refresh.sv
// Directed bench for oled_refresh with a small panel (4 columns, 2 pages, gap of 5) and a framebuffer model that returns base+column.
module tb_oled_refresh;

    localparam int COLS = 4;
    localparam int PGS  = 2;
    localparam int GAPN = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dspi_ready = 1'b1;
    logic [2:0] dspi_cmd;
    logic [7:0] dspi_byte;
    logic       d_read;
    logic [7:0] d_data = 8'h00;
    logic       d_data_ready = 1'b0;
    logic       frame_done;

    always #5 clk = ~clk;

    oled_refresh #(.COLUMNS(COLS), .PAGES(PGS), .FRAME_GAP(GAPN)) dut (
        .clk          (clk),
        .rst          (rst),
        .dspi_ready   (dspi_ready),
        .dspi_cmd     (dspi_cmd),
        .dspi_byte    (dspi_byte),
        .d_read       (d_read),
        .d_data       (d_data),
        .d_data_ready (d_data_ready),
        .frame_done   (frame_done)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [10:0] log_q[$];
    int          log_cyc[$];
    logic [10:0] exp_q[$];
    int cyc = 0, n_read = 0, n_done = 0, done_cyc = 0, last_read_cyc = 0, viol = 0;
    int rd_delay = 1, rd_wait = 0, m_col = 0;
    logic [7:0] rd_base = 8'h00, rd_val = 8'h00;
    logic prev_issue = 1'b0;

    // Monitor, protocol checker and framebuffer model in one process so that every signal has a single writer.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (dspi_cmd != 3'd0) begin
                if (!dspi_ready || rst || prev_issue || dspi_cmd > 3'd3) viol++;
                log_q.push_back({dspi_cmd, dspi_byte});
                log_cyc.push_back(cyc);
            end
            prev_issue = (dspi_cmd != 3'd0);
            if (rst) begin
                m_col   = 0;
                rd_wait = 0;
            end else begin
                if (d_read) begin
                    n_read++;
                    last_read_cyc = cyc;
                    rd_wait = rd_delay;
                    rd_val  = rd_base + 8'(m_col);
                    m_col   = (m_col + 1) % COLS;
                end
                if (frame_done) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
            d_data_ready = 1'b0;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    d_data_ready = 1'b1;
                    d_data       = rd_val;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            settle();
            k++;
        end
        check(tag, 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int k = 0;
        while (n_done < n && k < budget) begin
            settle();
            k++;
        end
        check(tag, 32'(n_done >= n), 32'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic push_init();
        exp_q.push_back({3'd1, 8'h00});
        exp_q.push_back({3'd2, 8'hAE});
        exp_q.push_back({3'd2, 8'h8D});
        exp_q.push_back({3'd2, 8'h14});
        exp_q.push_back({3'd2, 8'hAF});
    endtask

    task automatic push_page(input logic [2:0] p);
        exp_q.push_back({3'd2, 5'b10110, p});
        exp_q.push_back({3'd2, 8'h00});
        exp_q.push_back({3'd2, 8'h10});
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({3'd3, 8'(i)});
    endtask

    // HW_RESET carries no payload, so only its command code is compared.
    task automatic check_seq(input string tag, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= log_q.size()) begin
                check($sformatf("%s[%0d]_missing", tag, i), 32'd0, 32'd1);
            end else if (exp_q[i][10:8] == 3'd1) begin
                check($sformatf("%s[%0d]", tag, i), 32'(log_q[base+i][10:8]), 32'd1);
            end else begin
                check($sformatf("%s[%0d]", tag, i), 32'(log_q[base+i]), 32'(exp_q[i]));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base, r0, d0;

        // Outputs are quiet while rst is held, then the full power-up sequence and one frame are checked.
        repeat (2) tick();
        settle();
        check("rst_cmd", 32'(dspi_cmd), 32'd0);
        check("rst_byte", 32'(dspi_byte), 32'd0);
        check("rst_read", 32'(d_read), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_no_cmd", 32'(log_q.size()), 32'd0);
        tick();
        rst = 1'b0;
        base = log_q.size();
        wait_done(1, 400, "A_done_seen");
        check("A_reads", 32'(n_read), 32'(COLS * PGS));
        check("A_done_cnt", 32'(n_done), 32'd1);
        exp_q.delete();
        push_init();
        push_page(3'd0);
        push_data(COLS);
        push_page(3'd1);
        push_data(COLS);
        check_seq("A_seq", base);
        wait_log(base + 22, 100, "A_frame2_seen");
        check("A_gap", 32'(log_cyc[base+19] - done_cyc), 32'(GAPN + 1));
        exp_q.delete();
        push_page(3'd0);
        check_seq("A_frame2", base + 19);

        // A ready stall in the middle of INIT holds the third init byte until ready returns.
        do_reset();
        base = log_q.size();
        wait_log(base + 3, 50, "B_pre");
        tick();
        dspi_ready = 1'b0;
        repeat (20) tick();
        check("B_hold", 32'(log_q.size() - base), 32'd3);
        dspi_ready = 1'b1;
        wait_log(base + 5, 20, "B_resume_seen");
        exp_q.delete();
        push_init();
        check_seq("B_seq", base);
        check("B_resume", 32'(log_cyc[base+3] - log_cyc[base+2]), 32'd21);

        // A slow framebuffer response produces a single read, and DATA follows the strobe by one cycle.
        rd_delay = 10;
        rd_base  = 8'h50;
        do_reset();
        base = log_q.size();
        r0   = n_read;
        wait_log(base + 9, 100, "C_data_seen");
        check("C_reads", 32'(n_read - r0), 32'd1);
        check("C_byte", 32'(log_q[base+8]), 32'({3'd3, 8'h50}));
        check("C_latency", 32'(log_cyc[base+8] - last_read_cyc), 32'd11);

        // Resetting after the third DATA byte abandons the frame and restarts from HW_RESET.
        rd_delay = 1;
        rd_base  = 8'h00;
        do_reset();
        base = log_q.size();
        wait_log(base + 11, 150, "D_pre");
        d0 = n_done;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        wait_log(base + 20, 100, "D_restart_seen");
        exp_q.delete();
        push_init();
        push_page(3'd0);
        push_data(1);
        check_seq("D_seq", base + 11);
        check("D_no_done", 32'(n_done), 32'(d0));

        check("proto_viol", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
